// File: rtl/data_trans_pkg.sv
// Shared types and width constants for the data_trans nibble/byte packer.
package data_trans_pkg;

  localparam int DATA_W = 8;
  localparam int NIB_W  = 4;

  typedef enum logic [0:0] {
    IDLE          = 1'b0,
    S_UNSENT_DATA = 1'b1
  } state_t;

endpackage

// File: rtl/data_trans.sv
// Packs a LSB-first stream of bytes and nibbles into contiguous output bytes.
// Optional `pending` output when DATA_TRANS_PENDING_EN is defined.
module data_trans
  import data_trans_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              byt,
`ifdef DATA_TRANS_PENDING_EN
  output logic              pending,
`endif
  output logic [DATA_W-1:0] data_o,
  output logic              data_en
);

  state_t             state_cur;
  state_t             state_nxt;
  logic [NIB_W-1:0]   nib_q;
  logic [NIB_W-1:0]   nib_nxt;
  logic [DATA_W-1:0]  do_nxt;
  logic               en_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_cur <= IDLE;
      nib_q     <= '0;
      data_o    <= '0;
      data_en   <= 1'b0;
    end else begin
      state_cur <= state_nxt;
      nib_q     <= nib_nxt;
      data_o    <= do_nxt;
      data_en   <= en_nxt;
    end
  end

  // Upper nibble of data_in is only read on byt=1 paths.
  always_comb begin
    state_nxt = state_cur;
    nib_nxt   = nib_q;
    do_nxt    = data_o;
    en_nxt    = 1'b0;
    if (start) begin
      unique case (state_cur)
        IDLE: begin
          if (byt) begin
            do_nxt = data_in;
            en_nxt = 1'b1;
          end else begin
            nib_nxt   = data_in[NIB_W-1:0];
            state_nxt = S_UNSENT_DATA;
          end
        end
        S_UNSENT_DATA: begin
          do_nxt = {data_in[NIB_W-1:0], nib_q};
          en_nxt = 1'b1;
          if (byt) begin
            nib_nxt = data_in[DATA_W-1:NIB_W];
          end else begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

`ifdef DATA_TRANS_PENDING_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
    end else begin
      pending <= (state_nxt == S_UNSENT_DATA);
    end
  end
`endif

endmodule

// File: tb/tb_data_trans.sv
// Directed, table-driven bench for data_trans.
module tb_data_trans;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] data_in;
  logic       byt;
  logic [7:0] data_o;
  logic       data_en;
`ifdef DATA_TRANS_PENDING_EN
  logic       pending;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_trans dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .data_in (data_in),
    .byt     (byt),
`ifdef DATA_TRANS_PENDING_EN
    .pending (pending),
`endif
    .data_o  (data_o),
    .data_en (data_en)
  );

  typedef struct packed {
    logic       s;
    logic       b;
    logic [7:0] d;
    logic       en;
    logic [7:0] o;
    logic       st;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic b,
                      input logic [7:0] d);
    @(negedge clk);
    reset   = r;
    start   = s;
    byt     = b;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 8'h10, 1'b1, 8'h10, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 8'hF2, 1'b0, 8'h10, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 8'hCC, 1'b0, 8'h10, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 8'h43, 1'b1, 8'h32, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 8'h95, 1'b1, 8'h54, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 8'hE6, 1'b1, 8'h69, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 8'h87, 1'b1, 8'h87, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 8'hAA, 1'b0, 8'h87, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 8'h01, 1'b1, 8'h01, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 8'h02, 1'b1, 8'h02, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 8'h03, 1'b1, 8'h03, 1'b0};

    reset = 1'b1; start = 1'b0; byt = 1'b0; data_in = 8'h00;
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("rst_do", {24'h0, data_o}, 32'h00);
    chk("rst_en", {31'h0, data_en}, 32'h0);
    chk("rst_st", {31'h0, dut.state_cur}, 32'h0);
`ifdef DATA_TRANS_PENDING_EN
    chk("rst_pend", {31'h0, pending}, 32'h0);
`endif

    for (int i = 0; i < 11; i++) begin
      step(1'b0, tbl[i].s, tbl[i].b, tbl[i].d);
      chk($sformatf("vec%0d_en", i), {31'h0, data_en}, {31'h0, tbl[i].en});
      chk($sformatf("vec%0d_do", i), {24'h0, data_o}, {24'h0, tbl[i].o});
      chk($sformatf("vec%0d_st", i), {31'h0, dut.state_cur},
          {31'h0, tbl[i].st});
    end

    step(1'b0, 1'b1, 1'b0, 8'h9A);
    chk("idle_nibA_en", {31'h0, data_en}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h5C);
      chk($sformatf("gap%0d_en", i), {31'h0, data_en}, 32'h0);
      chk($sformatf("gap%0d_do", i), {24'h0, data_o}, 32'h03);
    end
    step(1'b0, 1'b1, 1'b0, 8'h7B);
    chk("gap_out_en", {31'h0, data_en}, 32'h1);
    chk("gap_out_do", {24'h0, data_o}, 32'hBA);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("gap_pulse1", {31'h0, data_en}, 32'h0);

    step(1'b0, 1'b1, 1'b0, 8'hD2);
    chk("hold2_st", {31'h0, dut.state_cur}, 32'h1);
    step(1'b1, 1'b1, 1'b1, 8'hFF);
    chk("mid_rst_do", {24'h0, data_o}, 32'h00);
    chk("mid_rst_en", {31'h0, data_en}, 32'h0);
    chk("mid_rst_st", {31'h0, dut.state_cur}, 32'h0);
    step(1'b0, 1'b1, 1'b1, 8'h55);
    chk("drop_en", {31'h0, data_en}, 32'h1);
    chk("drop_do", {24'h0, data_o}, 32'h55);

`ifdef DATA_TRANS_PENDING_EN
    step(1'b0, 1'b1, 1'b0, 8'hE7);
    chk("pend_set", {31'h0, pending}, 32'h1);
    chk("pend_set_en", {31'h0, data_en}, 32'h0);
    step(1'b0, 1'b1, 1'b0, 8'h38);
    chk("pend_clr", {31'h0, pending}, 32'h0);
    chk("pend_out_en", {31'h0, data_en}, 32'h1);
    chk("pend_out_do", {24'h0, data_o}, 32'h87);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_trans.md
DATA_TRANS -- requirements
Module: data_trans

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 8 bits and nibble width at 4 bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: data_in/byt are valid this cycle when 1.
REQ-005 The block SHALL have port data_in, input, 8 bits: input data; when byt=0 only [3:0] is meaningful, and [7:4] may be X.
REQ-006 The block SHALL have port byt, input, 1 bit: 1 means full byte valid, 0 means low nibble only.
REQ-007 The block SHALL have port data_o, output, 8 bits: packed output byte, registered.
REQ-008 The block SHALL have port data_en, output, 1 bit: data_o valid strobe, registered.

Function
REQ-009 The block SHALL pack a stream of bytes and nibbles, least-significant first, into contiguous output bytes.
REQ-010 The block SHALL implement two states: IDLE (no held bits) and S_UNSENT_DATA (4 held bits in a nibble register).
REQ-011 In IDLE with start=1 and byt=1, the next edge SHALL set data_o=data_in and data_en=1, and the state SHALL stay IDLE.
REQ-012 In IDLE with start=1 and byt=0, the block SHALL hold data_in[3:0], SET data_en=0 on the next edge, and go to S_UNSENT_DATA.
REQ-013 In S_UNSENT_DATA with start=1 and byt=1, the block SHALL set data_o={data_in[3:0], held} and data_en=1, hold data_in[7:4], and stay in S_UNSENT_DATA.
REQ-014 In S_UNSENT_DATA with start=1 and byt=0, the block SHALL set data_o={data_in[3:0], held} and data_en=1, and go to IDLE.
REQ-015 With start=0, the block SHALL ignore data_in and byt, set data_en=0, keep the state, and retain the held nibble indefinitely.
REQ-016 The latency from an accepted input to data_en SHALL be exactly 1 cycle; data_en SHALL be high for only one cycle per output byte.
REQ-017 When data_en=0, data_o SHALL keep its last value.
REQ-018 X on data_in[7:4] with byt=0 SHALL never propagate to data_o.
REQ-019 No backpressure SHALL exist; an input SHALL be accepted every cycle that start=1.

Reset
REQ-020 While reset=1 at a clock edge, the block SHALL set data_o=8'h00 and data_en=0, set the state to IDLE, and clear the held nibble to 4'h0.
REQ-021 A reset during S_UNSENT_DATA SHALL discard the held nibble without emitting it.
REQ-022 Reset SHALL take priority over start.

Configuration
REQ-023 With macro DATA_TRANS_PENDING_EN defined, the block SHALL add output port pending (1 bit), registered, equal to 1 exactly when the state is S_UNSENT_DATA, and 0 at reset.
REQ-024 Without DATA_TRANS_PENDING_EN, the port SHALL be absent and the rest of the behaviour SHALL be identical.

Structure
REQ-025 The package data_trans_pkg SHALL hold the state encoding (IDLE=1'b0, S_UNSENT_DATA=1'b1) and the width constants DATA_W=8 and NIB_W=4.
REQ-026 The state register SHALL be named state_cur, so benches can probe it hierarchically.
REQ-027 The block SHALL be a single module with no sub-module; the next-state and output logic are in one always block.

Verification
REQ-028 The bench SHALL cover reset=1 for 2 cycles, then release -> data_o=00, data_en=0, state IDLE.
REQ-029 The bench SHALL cover this cycle-by-cycle stream:
- 10/byt1
- x2/byt0
- start0
- 43/byt1
- 95/byt1
- x6/byt0
- 87/byt1
-> the data_en outputs SHALL be 10, 32, 54, 69, 87, with no output on the nibble cycle or the start0 cycle.
REQ-030 The bench SHALL cover IDLE with nibble A, then start=0 for 5 cycles, then nibble B -> a single output BA, with data_en low for the idle cycles.
REQ-031 The bench SHALL cover S_UNSENT_DATA holding 2, then reset asserted, then byte 55 -> output 55 (the held nibble is dropped).
REQ-032 The bench SHALL cover continuous full bytes 01, 02, 03 with start high -> outputs 01, 02, 03 on consecutive cycles, each 1 cycle later.
REQ-033 The bench SHALL cover, with DATA_TRANS_PENDING_EN defined, nibble 7 -> pending=1 on the next cycle; then nibble 8 -> pending=0 and output 87.
